// File: rtl/astar_pkg.sv
// Shared constants for the A* engine and its grid renderer: grid geometry,
// cell codes, colours and the tile address helper.
package astar_pkg;

  localparam logic [5:0]  GRID_N    = 6'd40;
  localparam int          CELL_SH   = 3;
  localparam logic [9:0]  X0        = 10'd160;
  localparam logic [9:0]  Y0        = 10'd80;
  localparam logic [9:0]  GRID_PX   = 10'd320;
  localparam int          DEPTH     = 1600;
  localparam int          ADDR_W    = 11;
  localparam logic [10:0] LAST_ADDR = 11'd1599;

  localparam logic [1:0] CELL_UNKNOWN  = 2'b00;
  localparam logic [1:0] CELL_GRID     = 2'b01;
  localparam logic [1:0] CELL_OBSTACLE = 2'b10;
  localparam logic [1:0] CELL_PATH     = 2'b11;

  localparam logic [7:0] COL_BLACK   = 8'h00;
  localparam logic [7:0] COL_PATH    = 8'h1C;
  localparam logic [7:0] COL_LINE    = 8'h92;
  localparam logic [7:0] COL_GRID    = 8'hFF;
  localparam logic [7:0] COL_UNKNOWN = 8'h49;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  // y*40 as (y<<5)+(y<<3) keeps the address path free of a multiplier
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
    logic [ADDR_W-1:0] yy;
    yy = {5'd0, y};
    return (yy << 5) + (yy << 3) + {5'd0, x};
  endfunction

endpackage

// File: rtl/astar_tile_ram.sv
// 1600x2 tile store: one synchronous write port, one registered read port
// returning the pre-write contents on a same-address collision.
module astar_tile_ram
  import astar_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [1:0]        wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [1:0]        rd
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/astar_grid_renderer.sv
// Grid renderer: takes A* cell-paint commands into the tile RAM and scans
// the tiles out as RRRGGGBB pixels behind a 2-clock pipeline.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | sweep writes UNKNOWN to every cell, commands held off, busy=1
// ST_RUN   | commands accepted and written, busy=0
module astar_grid_renderer
  import astar_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_req,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [5:0] cmd_x,
  input  logic [5:0] cmd_y,
  input  logic [1:0] cmd_type,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       pixel_active,
  output logic [7:0] rgb,
  output logic       busy,
  output logic       drop_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              drop_err_q;
  logic              in_grid_q, line_q;
  logic [7:0]        rgb_q, rgb_d;

  logic              accept, in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa, ram_ra;
  logic [1:0]        ram_wd, ram_rd;

  logic [9:0]        rx, ry;
  logic              in_grid, line;

  assign cmd_ready = (state_q == ST_RUN);
  assign busy      = (state_q == ST_CLEAR);
  assign drop_err  = drop_err_q;
  assign rgb       = rgb_q;

  // clear_req wins over a same-cycle command
  assign accept   = cmd_valid && cmd_ready && !clear_req;
  assign in_range = (cmd_x < GRID_N) && (cmd_y < GRID_N);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = 1'b0;
    ram_wa     = clr_addr_q;
    ram_wd     = CELL_UNKNOWN;
    case (state_q)
      ST_CLEAR: begin
        ram_we     = 1'b1;
        clr_addr_d = clr_addr_q + 11'd1;
        if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept && in_range) begin
          ram_we = 1'b1;
          ram_wa = cell_addr(cmd_x, cmd_y);
          ram_wd = cmd_type;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    if (clear_req) begin
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
    end
  end

  // Scanout stage 1: the RAM's read register doubles as the address stage
  assign rx      = pixel_x - X0;
  assign ry      = pixel_y - Y0;
  assign in_grid = pixel_active && (pixel_x >= X0) && (pixel_y >= Y0)
                   && (rx < GRID_PX) && (ry < GRID_PX);
  assign line    = (rx[CELL_SH-1:0] == '0) || (ry[CELL_SH-1:0] == '0);
  assign ram_ra  = in_grid ? cell_addr(6'(rx >> CELL_SH), 6'(ry >> CELL_SH)) : '0;

  always_comb begin
    rgb_d = COL_BLACK;
    if (in_grid_q) begin
      case (ram_rd)
        CELL_OBSTACLE: rgb_d = COL_BLACK;
        CELL_PATH:     rgb_d = COL_PATH;
        CELL_GRID:     rgb_d = line_q ? COL_LINE : COL_GRID;
        default:       rgb_d = line_q ? COL_LINE : COL_UNKNOWN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      drop_err_q <= 1'b0;
      in_grid_q  <= 1'b0;
      line_q     <= 1'b0;
      rgb_q      <= COL_BLACK;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      drop_err_q <= drop_err_q | (accept && !in_range);
      in_grid_q  <= in_grid;
      line_q     <= line;
      rgb_q      <= rgb_d;
    end
  end

  astar_tile_ram u_tile_ram (
    .clk (clk),
    .we  (ram_we),
    .wa  (ram_wa),
    .wd  (ram_wd),
    .ra  (ram_ra),
    .rd  (ram_rd)
  );

endmodule

// File: tb/tb_astar_grid_renderer.sv
// Bench for astar_grid_renderer: a tile model plus an rgb scoreboard queue
// that compares each pixel 2 clocks after it is driven.
module tb_astar_grid_renderer;

  logic       clk;
  logic       reset;
  logic       clear_req;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [5:0] cmd_x;
  logic [5:0] cmd_y;
  logic [1:0] cmd_type;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       pixel_active;
  logic [7:0] rgb;
  logic       busy;
  logic       drop_err;

  int errors = 0;
  int checks = 0;

  logic [1:0] model [1600];

  typedef struct {
    logic [7:0] exp;
    bit         chk;
    int         x;
    int         y;
  } exp_t;
  exp_t sb_q[$];

  astar_grid_renderer dut (
    .clk          (clk),
    .reset        (reset),
    .clear_req    (clear_req),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_type     (cmd_type),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_active (pixel_active),
    .rgb          (rgb),
    .busy         (busy),
    .drop_err     (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_rgb(input int x, input int y, input bit act);
    int rx, ry;
    logic [1:0] c;
    if (!act || x < 160 || x >= 480 || y < 80 || y >= 400) return 8'h00;
    rx = x - 160;
    ry = y - 80;
    c  = model[(ry / 8) * 40 + rx / 8];
    if (c == 2'b10) return 8'h00;
    if (c == 2'b11) return 8'h1C;
    if ((rx % 8) == 0 || (ry % 8) == 0) return 8'h92;
    if (c == 2'b01) return 8'hFF;
    return 8'h49;
  endfunction

  task automatic model_clear();
    foreach (model[i]) model[i] = 2'b00;
  endtask

  // One pixel per clock: retire the pixel driven two clocks ago, then drive the next
  task automatic pix_step(input int x, input int y, input bit act, input bit chk, input logic [7:0] exp);
    exp_t e;
    @(negedge clk);
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        checks++;
        if (rgb !== e.exp) begin
          errors++;
          $display("FAIL rgb pixel(%0d,%0d): got %h expected %h", e.x, e.y, rgb, e.exp);
        end
      end
    end
    pixel_x      = 10'(x);
    pixel_y      = 10'(y);
    pixel_active = act;
    e.exp = exp;
    e.chk = chk;
    e.x   = x;
    e.y   = y;
    sb_q.push_back(e);
  endtask

  task automatic pix_flush();
    pix_step(0, 0, 1'b0, 1'b0, 8'h00);
    pix_step(0, 0, 1'b0, 1'b0, 8'h00);
    sb_q.delete();
  endtask

  task automatic scan_sample();
    for (int y = 70; y < 410; y += 13)
      for (int x = 150; x < 490; x += 9)
        pix_step(x, y, 1'b1, 1'b1, model_rgb(x, y, 1'b1));
    pix_step(200, 200, 1'b0, 1'b1, 8'h00);
    pix_flush();
  endtask

  task automatic count_busy(output int n, output int not_ready_bad);
    n = 0;
    not_ready_bad = 0;
    while (busy === 1'b1 && n < 4000) begin
      if (cmd_ready !== 1'b0) not_ready_bad++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_req = 1'b0; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_type = '0;
    pixel_x = '0; pixel_y = '0; pixel_active = 1'b0;
    #3;
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
    checks++; if (rgb !== 8'h00)      begin errors++; $display("FAIL reset_rgb: got %h expected 00", rgb); end
    checks++; if (drop_err !== 1'b0)  begin errors++; $display("FAIL reset_drop: got %b expected 0", drop_err); end
  endtask

  task automatic test_sweep();
    int n, bad;
    @(negedge clk);
    reset = 1'b0;
    count_busy(n, bad);
    checks++; if (n != 1600) begin errors++; $display("FAIL sweep_len: got %0d cycles expected 1600", n); end
    checks++; if (bad != 0)  begin errors++; $display("FAIL sweep_ready: cmd_ready high in %0d busy cycles expected 0", bad); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL sweep_run_ready: got %b expected 1", cmd_ready); end
    model_clear();
    scan_sample();
  endtask

  task automatic test_paint();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_x = 6'd0; cmd_y = 6'd0; cmd_type = 2'b10;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL paint_ready0: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_x = 6'd39; cmd_y = 6'd39; cmd_type = 2'b11;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL paint_ready1: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_x = 6'd5; cmd_y = 6'd7; cmd_type = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    model[0] = 2'b10; model[39 * 40 + 39] = 2'b11; model[7 * 40 + 5] = 2'b01;
    pix_step(164, 84,   1'b1, 1'b1, 8'h00);
    pix_step(476, 396,  1'b1, 1'b1, 8'h1C);
    pix_step(204, 140,  1'b1, 1'b1, 8'hFF);
    pix_step(200, 140,  1'b1, 1'b1, 8'h92);
    pix_step(212, 140,  1'b1, 1'b1, 8'h49);
    pix_flush();
  endtask

  task automatic test_drop();
    int n, bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_x = 6'd40; cmd_y = 6'd3; cmd_type = 2'b01;
    @(negedge clk);
    cmd_x = 6'd3; cmd_y = 6'd40;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_set: got %b expected 1", drop_err); end
    pix_step(164, 116, 1'b1, 1'b1, 8'h49);
    pix_step(476, 108, 1'b1, 1'b1, 8'h49);
    pix_step(188, 84,  1'b1, 1'b1, 8'h49);
    pix_flush();
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b expected 1", drop_err); end
    count_busy(n, bad);
    checks++; if (n != 1600) begin errors++; $display("FAIL drop_sweep_len: got %0d expected 1600", n); end
    model_clear();
  endtask

  task automatic test_restart();
    int n, bad;
    @(negedge clk);
    clear_req = 1'b1;
    cmd_valid = 1'b1; cmd_x = 6'd10; cmd_y = 6'd10; cmd_type = 2'b11;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (799) @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    count_busy(n, bad);
    checks++; if (n != 1600) begin errors++; $display("FAIL restart_len: got %0d expected 1600", n); end
    checks++; if (bad != 0)  begin errors++; $display("FAIL restart_ready: cmd_ready high in %0d busy cycles", bad); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL restart_first_run: got %b expected 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    model_clear();
    model[10 * 40 + 10] = 2'b11;
    pix_step(243, 163, 1'b1, 1'b1, 8'h1C);
    pix_step(251, 163, 1'b1, 1'b1, 8'h49);
    pix_flush();
  endtask

  task automatic test_collision();
    pix_step(259, 243, 1'b1, 1'b1, model_rgb(259, 243, 1'b1));
    cmd_valid = 1'b1; cmd_x = 6'd12; cmd_y = 6'd20; cmd_type = 2'b10;
    model[20 * 40 + 12] = 2'b10;
    pix_step(0, 0, 1'b0, 1'b1, 8'h00);
    cmd_valid = 1'b0;
    pix_step(259, 243, 1'b1, 1'b1, model_rgb(259, 243, 1'b1));
    pix_flush();
  endtask

  task automatic test_reset_mid_run();
    int n, bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_x = 6'd1; cmd_y = 6'd1; cmd_type = 2'b01;
    pixel_x = 10'd403; pixel_y = 10'd323; pixel_active = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 8'h49)      begin errors++; $display("FAIL pre_reset_rgb: got %h expected 49", rgb); end
    checks++; if (drop_err !== 1'b1)  begin errors++; $display("FAIL pre_reset_drop: got %b expected 1", drop_err); end
    #2 reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", cmd_ready); end
    checks++; if (rgb !== 8'h00)      begin errors++; $display("FAIL mid_reset_rgb: got %h expected 00", rgb); end
    checks++; if (drop_err !== 1'b0)  begin errors++; $display("FAIL mid_reset_drop: got %b expected 0", drop_err); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL mid_reset_busy: got %b expected 1", busy); end
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0; pixel_active = 1'b0;
    count_busy(n, bad);
    checks++; if (n != 1600) begin errors++; $display("FAIL post_reset_len: got %0d expected 1600", n); end
    model_clear();
    pix_step(173, 93,  1'b1, 1'b1, 8'h49);
    pix_step(243, 163, 1'b1, 1'b1, 8'h49);
    pix_step(164, 84,  1'b1, 1'b1, 8'h49);
    pix_flush();
    scan_sample();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_paint();
    test_drop();
    test_restart();
    test_collision();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
